xor_cipher_sequencer: RTL and testbench

//  Top-level control FSM for the serial XOR-cipher datapath. Runs the fixed sequence:

---
 rtl/xor_cipher_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_xor_cipher_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_cipher_sequencer.sv
// Control FSM sequencing key load, message load, XOR encrypt and ciphertext serialization.
// Optional watchdog in ENCRYPT/SERIALIZE is built when XCS_WATCHDOG_EN is defined.
module xor_cipher_sequencer #(
  parameter int unsigned KEY_SIZE       = 8,
  parameter int unsigned MSG_SIZE       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        iKey_flag,
  input  logic                        iMsg_flag,
  input  logic                        iXor_done,
  input  logic                        iSer_done,
  output logic                        oKey_shift,
  output logic                        oMsg_shift,
  output logic                        oXor_start,
  output logic                        oSer_start,
  output logic                        oBusy,
  output logic                        oDone,
  output logic                        oError,
  output logic [2:0]                  oState,
  output logic [$clog2(KEY_SIZE):0]   oKey_count,
  output logic [$clog2(MSG_SIZE):0]   oMsg_count
);

  localparam int unsigned KCW = $clog2(KEY_SIZE) + 1;
  localparam int unsigned MCW = $clog2(MSG_SIZE) + 1;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_KEY  = 3'd1,
    S_WAIT_MSG  = 3'd2,
    S_LOAD_MSG  = 3'd3,
    S_ENCRYPT   = 3'd4,
    S_SERIALIZE = 3'd5,
    S_ERROR     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [KCW-1:0]   key_cnt_q, key_cnt_d;
  logic [MCW-1:0]   msg_cnt_q, msg_cnt_d;
  logic             xor_start_q, xor_start_d;
  logic             ser_start_q, ser_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic key_only, msg_only, any_flag;
  logic key_last, msg_last, key_room, msg_room;
  logic xor_done_ok, ser_done_ok, timeout;

  assign key_only = iKey_flag & ~iMsg_flag;
  assign msg_only = iMsg_flag & ~iKey_flag;
  assign any_flag = iKey_flag | iMsg_flag;
  assign key_last = (key_cnt_q == KCW'(KEY_SIZE - 1));
  assign msg_last = (msg_cnt_q == MCW'(MSG_SIZE - 1));
  assign key_room = (key_cnt_q < KCW'(KEY_SIZE));
  assign msg_room = (msg_cnt_q < MCW'(MSG_SIZE));

  // The start register doubles as the first-cycle marker, so done is ignored while it is high.
  assign xor_done_ok = iXor_done & ~xor_start_q;
  assign ser_done_ok = iSer_done & ~ser_start_q;

`ifdef XCS_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_q, wd_d;

  // Cycle counter restarts on every state change and counts enabled cycles in the wait states.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (state_q == S_ENCRYPT || state_q == S_SERIALIZE) begin
      wd_d = wd_q + WDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else if (ena) begin
      wd_q <= wd_d;
    end
  end

  assign timeout = (wd_q == WDW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a disabled cycle holds the current state.
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (iMsg_flag) begin
            state_d = S_ERROR;
          end else if (iKey_flag) begin
            state_d = key_last ? S_WAIT_MSG : S_LOAD_KEY;
          end
        end
        S_LOAD_KEY: begin
          if (!key_only) begin
            state_d = S_ERROR;
          end else if (key_last) begin
            state_d = S_WAIT_MSG;
          end
        end
        S_WAIT_MSG: begin
          if (iKey_flag) begin
            state_d = S_ERROR;
          end else if (iMsg_flag) begin
            state_d = msg_last ? S_ENCRYPT : S_LOAD_MSG;
          end
        end
        S_LOAD_MSG: begin
          if (!msg_only) begin
            state_d = S_ERROR;
          end else if (msg_last) begin
            state_d = S_ENCRYPT;
          end
        end
        S_ENCRYPT: begin
          if (any_flag) begin
            state_d = S_ERROR;
          end else if (xor_done_ok) begin
            state_d = S_SERIALIZE;
          end else if (timeout) begin
            state_d = S_ERROR;
          end
        end
        S_SERIALIZE: begin
          if (any_flag) begin
            state_d = S_ERROR;
          end else if (ser_done_ok) begin
            state_d = S_IDLE;
          end else if (timeout) begin
            state_d = S_ERROR;
          end
        end
        S_ERROR: begin
          if (!any_flag) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: combinational shifts plus next values of registered outputs and counters.
  always_comb begin
    oKey_shift  = 1'b0;
    oMsg_shift  = 1'b0;
    xor_start_d = 1'b0;
    ser_start_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    key_cnt_d   = key_cnt_q;
    msg_cnt_d   = msg_cnt_q;

    oKey_shift = ena & key_only & key_room &
                 ((state_q == S_IDLE) | (state_q == S_LOAD_KEY));
    oMsg_shift = ena & msg_only & msg_room &
                 ((state_q == S_WAIT_MSG) | (state_q == S_LOAD_MSG));

    xor_start_d = (state_d == S_ENCRYPT)   && (state_q != S_ENCRYPT);
    ser_start_d = (state_d == S_SERIALIZE) && (state_q != S_SERIALIZE);
    busy_d      = (state_d != S_IDLE) && (state_d != S_ERROR);
    done_d      = (state_q == S_SERIALIZE) && (state_d == S_IDLE);
    error_d     = (state_d == S_ERROR);

    // Any return to IDLE (completion or error recovery) starts a fresh transfer.
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      key_cnt_d = '0;
      msg_cnt_d = '0;
    end else begin
      if (oKey_shift) key_cnt_d = key_cnt_q + KCW'(1);
      if (oMsg_shift) msg_cnt_d = msg_cnt_q + MCW'(1);
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_cnt_q   <= '0;
      msg_cnt_q   <= '0;
      xor_start_q <= 1'b0;
      ser_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else if (ena) begin
      key_cnt_q   <= key_cnt_d;
      msg_cnt_q   <= msg_cnt_d;
      xor_start_q <= xor_start_d;
      ser_start_q <= ser_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign oXor_start = xor_start_q;
  assign oSer_start = ser_start_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oError     = error_q;
  assign oState     = state_q;
  assign oKey_count = key_cnt_q;
  assign oMsg_count = msg_cnt_q;

endmodule

// File: tb/tb_xor_cipher_sequencer.sv
// Scoreboard bench for xor_cipher_sequencer: a cycle model pushes expected outputs, the monitor pops and compares.
module tb_xor_cipher_sequencer;

  localparam int KEY_SIZE = 8;
  localparam int MSG_SIZE = 64;
  localparam int TMO      = 16;

  logic       clk, rst, ena;
  logic       iKey_flag, iMsg_flag, iXor_done, iSer_done;
  logic       oKey_shift, oMsg_shift, oXor_start, oSer_start, oBusy, oDone, oError;
  logic [2:0] oState;
  logic [3:0] oKey_count;
  logic [6:0] oMsg_count;

  xor_cipher_sequencer #(
    .KEY_SIZE(KEY_SIZE), .MSG_SIZE(MSG_SIZE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .iKey_flag(iKey_flag), .iMsg_flag(iMsg_flag),
    .iXor_done(iXor_done), .iSer_done(iSer_done),
    .oKey_shift(oKey_shift), .oMsg_shift(oMsg_shift),
    .oXor_start(oXor_start), .oSer_start(oSer_start),
    .oBusy(oBusy), .oDone(oDone), .oError(oError),
    .oState(oState), .oKey_count(oKey_count), .oMsg_count(oMsg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st, kc, mc, xs, ss, busy, done, err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_xs = 0, n_ss = 0, n_done = 0;

  // Reference model state (per the protocol, not the RTL structure).
  int m_st = 0, m_kc = 0, m_mc = 0, m_wd = 0;
  int m_xs = 0, m_ss = 0, m_busy = 0, m_done = 0, m_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_kc = 0; m_mc = 0; m_wd = 0;
    m_xs = 0; m_ss = 0; m_busy = 0; m_done = 0; m_err = 0;
  endtask

  // One clock: drive, check comb shifts, advance model, push, wait edge, pop and compare.
  task automatic cycle(input bit k, input bit m, input bit xd, input bit sd,
                       input bit en, input bit r);
    exp_t e;
    int   ks, ms, nx, tmo;
    rst = r; ena = en; iKey_flag = k; iMsg_flag = m; iXor_done = xd; iSer_done = sd;
    #2;
    ks = (en && k && !m && (m_st == 0 || m_st == 1) && m_kc < KEY_SIZE) ? 1 : 0;
    ms = (en && m && !k && (m_st == 2 || m_st == 3) && m_mc < MSG_SIZE) ? 1 : 0;
    chk("key_shift", 32'(oKey_shift), ks);
    chk("msg_shift", 32'(oMsg_shift), ms);
    if (r) begin
      model_reset();
    end else if (en) begin
      nx  = m_st;
      tmo = 0;
`ifdef XCS_WATCHDOG_EN
      tmo = (m_wd == TMO - 1) ? 1 : 0;
`endif
      case (m_st)
        0: if (m) nx = 7; else if (k) nx = (m_kc + 1 == KEY_SIZE) ? 2 : 1;
        1: if (m || !k) nx = 7; else if (m_kc + 1 == KEY_SIZE) nx = 2;
        2: if (k) nx = 7; else if (m) nx = (m_mc + 1 == MSG_SIZE) ? 4 : 3;
        3: if (k || !m) nx = 7; else if (m_mc + 1 == MSG_SIZE) nx = 4;
        4: if (k || m) nx = 7; else if (xd && m_xs == 0) nx = 5; else if (tmo != 0) nx = 7;
        5: if (k || m) nx = 7; else if (sd && m_ss == 0) nx = 0; else if (tmo != 0) nx = 7;
        7: if (!k && !m) nx = 0;
        default: nx = 0;
      endcase
      m_kc  += ks;
      m_mc  += ms;
      m_xs   = (nx == 4 && m_st != 4) ? 1 : 0;
      m_ss   = (nx == 5 && m_st != 5) ? 1 : 0;
      m_done = (m_st == 5 && nx == 0) ? 1 : 0;
      m_busy = (nx != 0 && nx != 7) ? 1 : 0;
      m_err  = (nx == 7) ? 1 : 0;
      if (nx == 0 && m_st != 0) begin
        m_kc = 0; m_mc = 0;
      end
      m_wd = (nx != m_st) ? 0 : m_wd + 1;
      m_st = nx;
    end
    e = '{m_st, m_kc, m_mc, m_xs, m_ss, m_busy, m_done, m_err};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("state",     32'(oState),     e.st);
    chk("key_count", 32'(oKey_count), e.kc);
    chk("msg_count", 32'(oMsg_count), e.mc);
    chk("xor_start", 32'(oXor_start), e.xs);
    chk("ser_start", 32'(oSer_start), e.ss);
    chk("busy",      32'(oBusy),      e.busy);
    chk("done",      32'(oDone),      e.done);
    chk("error",     32'(oError),     e.err);
    n_xs   += 32'(oXor_start);
    n_ss   += 32'(oSer_start);
    n_done += 32'(oDone);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic load(input int kn, input int mn);
    for (int i = 0; i < kn; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < mn; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic finish_run();
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(70);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1;
    iKey_flag = 1'b0; iMsg_flag = 1'b0; iXor_done = 1'b0; iSer_done = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset_state", 32'(oState), 0);
    chk("reset_busy",  32'(oBusy),  0);
    idle(2);

    // Nominal transfer.
    n_xs = 0; n_ss = 0; n_done = 0;
    load(KEY_SIZE, MSG_SIZE);
    chk("nom_enc_state", 32'(oState), 4);
    finish_run();
    chk("nom_xor_pulses", n_xs, 1);
    chk("nom_ser_pulses", n_ss, 1);
    chk("nom_done_pulses", n_done, 1);
    chk("nom_end_state", 32'(oState), 0);
    chk("nom_end_kcnt", 32'(oKey_count), 0);

    // Short key, then recovery.
    load(5, 0);
    idle(1);
    chk("short_key_state", 32'(oState), 7);
    chk("short_key_err",   32'(oError), 1);
    idle(1);
    chk("short_key_recover", 32'(oState), 0);

    // Contention and message-first in IDLE.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("both_flags_state", 32'(oState), 7);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("msg_first_state", 32'(oState), 7);
    idle(1);

    // Protocol violations in later states.
    load(KEY_SIZE, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("extra_key_state", 32'(oState), 7);
    idle(1);
    load(3, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    load(KEY_SIZE, MSG_SIZE);
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("busy_restart_state", 32'(oState), 7);
    idle(2);

    // ena gating mid message load.
    load(KEY_SIZE, 30);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ena_hold_cnt",   32'(oMsg_count), 30);
    chk("ena_hold_state", 32'(oState), 3);
    load(0, MSG_SIZE - 30);
    chk("ena_resume_state", 32'(oState), 4);
    finish_run();

    // Reset during ENCRYPT, then a stray done.
    load(KEY_SIZE, MSG_SIZE);
    idle(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_mid_state", 32'(oState), 0);
    chk("rst_mid_kcnt",  32'(oKey_count), 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_stray_done", 32'(oState), 0);

    // Watchdog / indefinite wait with no encrypt done.
    load(KEY_SIZE, MSG_SIZE);
    idle(TMO);
`ifdef XCS_WATCHDOG_EN
    chk("wd_timeout_state", 32'(oState), 7);
`else
    chk("no_wd_state_16", 32'(oState), 4);
`endif
    idle(1000 - TMO);
`ifdef XCS_WATCHDOG_EN
    chk("wd_after_state", 32'(oState), 0);
`else
    chk("no_wd_state_1000", 32'(oState), 4);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
